// File: rtl/list_sequencer.sv
// ---------------------------------------------------------------------------
// list_sequencer
//
// Walks all 64 (A[i], B[j]) element pairs of two latched 8x4-bit operand
// vectors, issues each pair as a request to an external registered
// partial-product table, and accumulates the returned terms into a 23-bit
// sum. The result is published with a one-cycle done pulse.
//
// Ports
//   clk     in   1  system clock, all logic on posedge
//   rst_n   in   1  synchronous active-low reset
//   start   in   1  request a new operation (sampled only while idle)
//   a_vec   in  32  eight 4-bit elements, A[k] = a_vec[4k+3:4k]
//   b_vec   in  32  eight 4-bit elements, B[k] = b_vec[4k+3:4k]
//   data    in  17  table term, valid one clock after its request
//   comp1   out  4  A[i] of the pair being requested
//   comp2   out  4  B[j] of the pair being requested
//   i       out  3  outer pair index
//   j       out  3  inner pair index
//   busy    out  1  operation in progress
//   done    out  1  one-cycle completion pulse
//   result  out 23  final accumulated sum of the last completed operation
//
// Configuration
//   LIST_SEQ_DATA_PIPE_EN  when defined, data passes through one extra
//                          register before the accumulator; completion is
//                          one clock later and DRAIN lasts two cycles.
// ---------------------------------------------------------------------------
module list_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_vec,
    input  logic [31:0] b_vec,
    input  logic [16:0] data,
    output logic [3:0]  comp1,
    output logic [3:0]  comp2,
    output logic [2:0]  i,
    output logic [2:0]  j,
    output logic        busy,
    output logic        done,
    output logic [22:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    // Index of the next pair to issue; bit 6 set means all 64 have gone out.
    logic [6:0]  cnt;
    // vld_p0: a request is on comp1/comp2/i/j this cycle.
    // vld_p1: the table term for that request is on data this cycle.
    logic        vld_p0;
    logic        vld_p1;
    logic [22:0] acc;

    logic [16:0] acc_term;
    logic        acc_vld;
    logic        prev_vld;
    logic [22:0] acc_next;

    function automatic logic [3:0] elem(input logic [31:0] vec, input logic [2:0] idx);
        return vec[{idx, 2'b00} +: 4];
    endfunction

`ifdef LIST_SEQ_DATA_PIPE_EN
    logic [16:0] data_p2;
    logic        vld_p2;

    // Extra data register; carries no control meaning, so no reset.
    always_ff @(posedge clk) begin
        data_p2 <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_p2 <= 1'b0;
        else        vld_p2 <= vld_p1;
    end

    assign acc_term = data_p2;
    assign acc_vld  = vld_p2;
    assign prev_vld = vld_p1;
`else
    assign acc_term = data;
    assign acc_vld  = vld_p1;
    assign prev_vld = vld_p0;
`endif

    // Terms are unsigned and the worst-case total fits in 23 bits.
    assign acc_next = acc + {6'd0, acc_term};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            comp1  <= '0;
            comp2  <= '0;
            i      <= '0;
            j      <= '0;
            cnt    <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= vld_p0;
            if (acc_vld) acc <= acc_next;

            case (state)
                IDLE: begin
                    comp1  <= '0;
                    comp2  <= '0;
                    i      <= '0;
                    j      <= '0;
                    vld_p0 <= 1'b0;
                    if (start) begin
                        a_lat  <= a_vec;
                        b_lat  <= b_vec;
                        acc    <= '0;
                        busy   <= 1'b1;
                        // Pair 0 goes out straight from the inputs so it is
                        // visible in the cycle right after the start edge.
                        comp1  <= elem(a_vec, 3'd0);
                        comp2  <= elem(b_vec, 3'd0);
                        vld_p0 <= 1'b1;
                        cnt    <= 7'd1;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (cnt[6]) begin
                        comp1  <= '0;
                        comp2  <= '0;
                        i      <= '0;
                        j      <= '0;
                        vld_p0 <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        comp1  <= elem(a_lat, cnt[5:3]);
                        comp2  <= elem(b_lat, cnt[2:0]);
                        i      <= cnt[5:3];
                        j      <= cnt[2:0];
                        vld_p0 <= 1'b1;
                        cnt    <= cnt + 7'd1;
                    end
                end

                DRAIN: begin
                    // The last term is the one whose successor stage is empty.
                    if (acc_vld && !prev_vld) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_list_sequencer.sv
module tb_list_sequencer;

`ifdef LIST_SEQ_DATA_PIPE_EN
    localparam int LAT = 66;
`else
    localparam int LAT = 65;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_vec;
    logic [31:0] b_vec;
    logic [16:0] data;
    logic [3:0]  comp1;
    logic [3:0]  comp2;
    logic [2:0]  i;
    logic [2:0]  j;
    logic        busy;
    logic        done;
    logic [22:0] result;

    int n_cmp;
    int n_bad;

    logic [2:0] rom [256];

    list_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_vec  (a_vec),
        .b_vec  (b_vec),
        .data   (data),
        .comp1  (comp1),
        .comp2  (comp2),
        .i      (i),
        .j      (j),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered partial-product table.
    always @(posedge clk) begin
        data <= {14'd0, rom[{comp1, comp2}]} << ({1'b0, i} + {1'b0, j});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom_all(input logic [2:0] v);
        for (int k = 0; k < 256; k++) rom[k] = v;
    endtask

    // Ticks until done is seen (bounded); k is the number of ticks taken.
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a_vec = '0;
        b_vec = '0;
        tick();
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (result !== 23'd0) begin n_bad++; $display("FAIL reset_result: got %0d want 0", result); end
        n_cmp++;
        if ({comp1, comp2, i, j} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_req: got comp1=%0d comp2=%0d i=%0d j=%0d want all 0", comp1, comp2, i, j);
        end
    endtask

    task automatic test_sequence();
        int k;
        set_rom_all(3'd0);
        rom[8'h18] = 3'd1;   // A[0]=1, B[0]=8 -> 1 << 0
        rom[8'h3B] = 3'd5;   // A[2]=3, B[3]=B -> 5 << 5
        a_vec = 32'h87654321;
        b_vec = 32'hFEDCBA98;
        start = 1'b1;
        tick();              // E0
        start = 1'b0;
        n_cmp++;
        if ({comp1, comp2, i, j} !== {4'd1, 4'd8, 3'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL seq_e0: got comp1=%0d comp2=%0d i=%0d j=%0d want 1 8 0 0", comp1, comp2, i, j);
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL seq_busy: got %b want 1", busy); end
        // Operands change after the start edge; the latched ones must be used.
        a_vec = 32'h0;
        b_vec = 32'h0;
        tick();              // E1
        n_cmp++;
        if ({comp1, comp2, i, j} !== {4'd1, 4'd9, 3'd0, 3'd1}) begin
            n_bad++;
            $display("FAIL seq_e1: got comp1=%0d comp2=%0d i=%0d j=%0d want 1 9 0 1", comp1, comp2, i, j);
        end
        for (int t = 0; t < 7; t++) tick();   // E8
        n_cmp++;
        if ({comp1, comp2, i, j} !== {4'd2, 4'd8, 3'd1, 3'd0}) begin
            n_bad++;
            $display("FAIL seq_e8: got comp1=%0d comp2=%0d i=%0d j=%0d want 2 8 1 0", comp1, comp2, i, j);
        end
        n_cmp++;
        if (result !== 23'd0) begin n_bad++; $display("FAIL seq_no_partial: got %0d want 0", result); end
        wait_done(k);
        n_cmp++;
        if (k + 8 !== LAT) begin n_bad++; $display("FAIL seq_latency: got %0d want %0d", k + 8, LAT); end
        n_cmp++;
        if (result !== 23'd161) begin n_bad++; $display("FAIL seq_result: got %0d want 161", result); end
        tick();
        n_cmp++;
        if ({comp1, comp2, i, j} !== 14'd0) begin
            n_bad++;
            $display("FAIL seq_idle_req: got comp1=%0d comp2=%0d i=%0d j=%0d want all 0", comp1, comp2, i, j);
        end
    endtask

    task automatic test_all_ones();
        int k;
        set_rom_all(3'd1);
        a_vec = 32'h13579BDF;
        b_vec = 32'h2468ACE0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        n_cmp++;
        if (k !== LAT) begin n_bad++; $display("FAIL ones_latency: got %0d want %0d", k, LAT); end
        n_cmp++;
        if (result !== 23'd65025) begin n_bad++; $display("FAIL ones_result: got %0d want 65025", result); end
        tick();
    endtask

    task automatic test_all_sevens();
        int k;
        int busy_cnt;
        int done_cnt;
        set_rom_all(3'd7);
        a_vec = 32'hFFFFFFFF;
        b_vec = 32'h00000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        k = 0;
        while (k < LAT + 5) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 30) begin
                n_cmp++;
                if (result !== 23'd65025) begin n_bad++; $display("FAIL sevens_hold: got %0d want 65025", result); end
            end
            tick();
            k++;
        end
        n_cmp++;
        if (busy_cnt !== LAT) begin n_bad++; $display("FAIL sevens_busy_cycles: got %0d want %0d", busy_cnt, LAT); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL sevens_done_cycles: got %0d want 1", done_cnt); end
        n_cmp++;
        if (result !== 23'd455175) begin n_bad++; $display("FAIL sevens_result: got %0d want 455175", result); end
    endtask

    task automatic test_reset_abort();
        int k;
        int done_cnt;
        set_rom_all(3'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 30; t++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++;
        if (result !== 23'd0) begin n_bad++; $display("FAIL abort_result: got %0d want 0", result); end
        done_cnt = 0;
        for (int t = 0; t < 80; t++) begin
            if (done) done_cnt++;
            tick();
        end
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        n_cmp++;
        if (k !== LAT) begin n_bad++; $display("FAIL abort_rerun_latency: got %0d want %0d", k, LAT); end
        n_cmp++;
        if (result !== 23'd65025) begin n_bad++; $display("FAIL abort_rerun_result: got %0d want 65025", result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        set_rom_all(3'd1);
        start = 1'b1;
        tick();              // first start accepted
        wait_done(k);
        n_cmp++;
        if (k !== LAT) begin n_bad++; $display("FAIL b2b_first: got %0d want %0d", k, LAT); end
        n_cmp++;
        if (result !== 23'd65025) begin n_bad++; $display("FAIL b2b_result1: got %0d want 65025", result); end
        // start stays high: the done cycle accepts the next operation.
        tick();
        k = 1;
        while (!done && k < 300) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k !== LAT + 1) begin n_bad++; $display("FAIL b2b_interval: got %0d want %0d", k, LAT + 1); end
        n_cmp++;
        if (result !== 23'd65025) begin n_bad++; $display("FAIL b2b_result2: got %0d want 65025", result); end
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_stop: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        set_rom_all(3'd0);
        test_reset();
        test_sequence();
        test_all_ones();
        test_all_sevens();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
